// File: rtl/pool_sched.sv
// Round-robin scheduler sharing one maxpool datapath among NUM_REQ requesters.
// Optional completed-job counter enabled by defining POOL_SCHED_STATS_EN.
module pool_sched #(
  parameter int NUM_REQ = 4,
  parameter int LAT     = 1,
  parameter int SEL_W   = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [SEL_W-1:0]   sel,
  output logic               pool_valid_in,
  input  logic               pool_valid_out,
  output logic [NUM_REQ-1:0] done,
  output logic               busy,
  output logic [15:0]        job_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [3:0]       LAT_C    = 4'(LAT);
  localparam logic [SEL_W:0]   NUM_C    = (SEL_W+1)'(NUM_REQ);
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_REQ - 1);

  state_t             r_state;
  state_t             w_state_next;
  logic [NUM_REQ-1:0] r_gnt;
  logic [SEL_W-1:0]   r_sel;
  logic [SEL_W-1:0]   r_rr_ptr;
  logic [3:0]         r_cnt;

  logic               w_any;
  logic [SEL_W-1:0]   w_pick;
  logic [SEL_W-1:0]   w_ptr_inc;
  logic               w_unused_pvo;

  // The datapath keeps its valid high after the first job, so sequencing
  // relies solely on the latency counter.
  assign w_unused_pvo = pool_valid_out;

  assign w_any = |req;

  // Scan from the highest offset down so the lowest offset from rr_ptr wins.
  always_comb begin
    logic [SEL_W:0] w_idx;
    w_pick = '0;
    w_idx  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      w_idx = {1'b0, r_rr_ptr} + (SEL_W+1)'(i);
      if (w_idx >= NUM_C) begin
        w_idx = w_idx - NUM_C;
      end
      if (req[w_idx[SEL_W-1:0]]) begin
        w_pick = w_idx[SEL_W-1:0];
      end
    end
  end

  assign w_ptr_inc = (r_sel == LAST_IDX) ? '0 : r_sel + SEL_W'(1);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_any) w_state_next = ISSUE;
      ISSUE:   w_state_next = WAIT;
      WAIT:    if (r_cnt == 4'd1) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_gnt    <= '0;
      r_sel    <= '0;
      r_rr_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_gnt <= NUM_REQ'(1) << w_pick;
            r_sel <= w_pick;
          end else begin
            r_gnt <= '0;
            r_sel <= '0;
          end
        end
        ISSUE: r_cnt <= LAT_C;
        WAIT:  r_cnt <= r_cnt - 4'd1;
        DONE: begin
          // Requester just served drops to lowest priority for the next search.
          r_rr_ptr <= w_ptr_inc;
          r_gnt    <= '0;
          r_sel    <= '0;
          r_cnt    <= '0;
        end
        default: r_cnt <= '0;
      endcase
    end
  end

`ifdef POOL_SCHED_STATS_EN
  logic [15:0] r_job_count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_job_count <= '0;
    end else if (r_state == DONE && r_job_count != 16'hFFFF) begin
      r_job_count <= r_job_count + 16'd1;
    end
  end

  assign job_count = r_job_count;
`else
  assign job_count = '0;
`endif

  assign gnt           = r_gnt;
  assign sel           = r_sel;
  assign pool_valid_in = (r_state == ISSUE);
  assign done          = (r_state == DONE) ? r_gnt : '0;
  assign busy          = (r_state != IDLE);

endmodule

// File: tb/tb_pool_sched.sv
// Bench for pool_sched: directed table on a LAT=1 instance, hand sequences on a
// LAT=5 instance, then randomized traffic on both against a job-timeline model.
module tb_pool_sched;

`ifdef POOL_SCHED_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic       clk;
  logic       rst_n  [2];
  logic [3:0] req_v  [2];
  logic       pvo_v  [2];
  logic [3:0] gnt_v  [2];
  logic [1:0] sel_v  [2];
  logic       pvi_v  [2];
  logic [3:0] done_v [2];
  logic       busy_v [2];
  logic [15:0] jc_v  [2];

  int n_tests = 0;
  int n_fail  = 0;

  pool_sched #(.NUM_REQ(4), .LAT(1)) dut (
    .clk(clk), .rst(rst_n[0]), .req(req_v[0]), .gnt(gnt_v[0]), .sel(sel_v[0]),
    .pool_valid_in(pvi_v[0]), .pool_valid_out(pvo_v[0]), .done(done_v[0]),
    .busy(busy_v[0]), .job_count(jc_v[0])
  );

  pool_sched #(.NUM_REQ(4), .LAT(5)) dut5 (
    .clk(clk), .rst(rst_n[1]), .req(req_v[1]), .gnt(gnt_v[1]), .sel(sel_v[1]),
    .pool_valid_in(pvi_v[1]), .pool_valid_out(pvo_v[1]), .done(done_v[1]),
    .busy(busy_v[1]), .job_count(jc_v[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       pvi;
    logic [3:0] done;
    logic       busy;
  } vec_t;

  vec_t vecs[$];

  task automatic tick();
    pvo_v[1] = ~pvo_v[1];
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(string name, int i, logic [3:0] eg, logic [1:0] es,
                           logic ep, logic [3:0] ed, logic eb);
    n_tests++;
    if (gnt_v[i] !== eg || sel_v[i] !== es || pvi_v[i] !== ep ||
        done_v[i] !== ed || busy_v[i] !== eb) begin
      n_fail++;
      $display("FAIL %s inst%0d: got gnt=%b sel=%0d pvi=%b done=%b busy=%b, want gnt=%b sel=%0d pvi=%b done=%b busy=%b",
               name, i, gnt_v[i], sel_v[i], pvi_v[i], done_v[i], busy_v[i], eg, es, ep, ed, eb);
    end
  endtask

  task automatic check_jc(string name, int i, logic [15:0] ejc);
    n_tests++;
    if (jc_v[i] !== ejc) begin
      n_fail++;
      $display("FAIL %s inst%0d: got job_count=%0d, want %0d", name, i, jc_v[i], ejc);
    end
  endtask

  task automatic add_row(logic [3:0] rq, logic [3:0] g, logic [1:0] s, logic p,
                         logic [3:0] d, logic b);
    vec_t v;
    v.req = rq; v.gnt = g; v.sel = s; v.pvi = p; v.done = d; v.busy = b;
    vecs.push_back(v);
  endtask

  // One job on a LAT=1 instance: ISSUE, WAIT, DONE, then back in IDLE.
  task automatic add_job(logic [3:0] rq_issue, logic [3:0] rq_hold, int w);
    logic [3:0] g;
    g = 4'b0001 << w;
    add_row(rq_issue, g, 2'(w), 1'b1, 4'b0000, 1'b1);
    add_row(rq_hold,  g, 2'(w), 1'b0, 4'b0000, 1'b1);
    add_row(rq_hold,  g, 2'(w), 1'b0, g,       1'b1);
    add_row(rq_hold,  4'b0000, 2'd0, 1'b0, 4'b0000, 1'b0);
  endtask

  function automatic int pick(logic [3:0] r, int p);
    for (int k = 0; k < 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return 0;
  endfunction

  // Reference model: a job is described by its age (cycles since grant).
  int m_age   [2];
  int m_owner [2];
  int m_ptr   [2];
  int m_jobs  [2];
  int lat_of  [2];

  initial begin
    lat_of[0] = 1;
    lat_of[1] = 5;
    for (int i = 0; i < 2; i++) begin
      rst_n[i] = 1'b0;
      req_v[i] = 4'b0000;
      pvo_v[i] = 1'b0;
    end
    tick();
    for (int i = 0; i < 2; i++) begin
      check_out("reset_state", i, 4'b0000, 2'd0, 1'b0, 4'b0000, 1'b0);
      check_jc("reset_jc", i, 16'd0);
      rst_n[i] = 1'b1;
    end

    // Directed table on the LAT=1 instance (rr_ptr starts at 0).
    for (int j = 0; j < 5; j++) add_job(4'b1111, 4'b1111, j % 4);
    add_job(4'b0100, 4'b0100, 2);
    add_job(4'b0011, 4'b0011, 0);
    add_job(4'b0011, 4'b0011, 1);
    add_job(4'b1000, 4'b0000, 3);
    add_row(4'b0000, 4'b0000, 2'd0, 1'b0, 4'b0000, 1'b0);
    for (int k = 0; k < vecs.size(); k++) begin
      req_v[0] = vecs[k].req;
      tick();
      check_out($sformatf("table_row%0d", k), 0, vecs[k].gnt, vecs[k].sel,
                vecs[k].pvi, vecs[k].done, vecs[k].busy);
    end
    $display("[TB] table: %0d rows applied", vecs.size());

    // Latency sweep on LAT=5 with pool_valid_out toggling every cycle.
    req_v[1] = 4'b0001;
    tick();
    check_out("sweep_issue", 1, 4'b0001, 2'd0, 1'b1, 4'b0000, 1'b1);
    for (int k = 0; k < 5; k++) begin
      tick();
      check_out($sformatf("sweep_wait%0d", k), 1, 4'b0001, 2'd0, 1'b0, 4'b0000, 1'b1);
    end
    tick();
    check_out("sweep_done", 1, 4'b0001, 2'd0, 1'b0, 4'b0001, 1'b1);
    req_v[1] = 4'b0000;
    tick();
    check_out("sweep_idle", 1, 4'b0000, 2'd0, 1'b0, 4'b0000, 1'b0);
    $display("[TB] sweep: LAT=5 job done");

    // Reset during WAIT abandons the job and restarts the search at 0.
    req_v[1] = 4'b0010;
    tick();
    check_out("rst_issue", 1, 4'b0010, 2'd1, 1'b1, 4'b0000, 1'b1);
    tick();
    tick();
    rst_n[1] = 1'b0;
    tick();
    check_out("rst_mid", 1, 4'b0000, 2'd0, 1'b0, 4'b0000, 1'b0);
    check_jc("rst_mid_jc", 1, 16'd0);
    rst_n[1] = 1'b1;
    req_v[1] = 4'b1001;
    tick();
    check_out("post_rst_grant", 1, 4'b0001, 2'd0, 1'b1, 4'b0000, 1'b1);
    req_v[1] = 4'b0000;
    for (int k = 0; k < 5; k++) tick();
    check_out("post_rst_wait", 1, 4'b0001, 2'd0, 1'b0, 4'b0000, 1'b1);
    tick();
    check_out("post_rst_done", 1, 4'b0001, 2'd0, 1'b0, 4'b0001, 1'b1);
    tick();
    $display("[TB] reset mid-job: sequence done");

    // Randomized traffic on both instances against the model.
    for (int i = 0; i < 2; i++) begin
      rst_n[i] = 1'b0;
      req_v[i] = 4'b0000;
    end
    tick();
    for (int i = 0; i < 2; i++) begin
      rst_n[i]   = 1'b1;
      m_age[i]   = 0;
      m_owner[i] = 0;
      m_ptr[i]   = 0;
      m_jobs[i]  = 0;
    end
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < 2; i++) begin
        logic [3:0] eg;
        logic [3:0] ed;
        logic [3:0] nreq;
        eg = (m_age[i] != 0) ? (4'b0001 << m_owner[i]) : 4'b0000;
        ed = (m_age[i] == lat_of[i] + 2) ? eg : 4'b0000;
        check_out("rand", i, eg, (m_age[i] != 0) ? 2'(m_owner[i]) : 2'd0,
                  m_age[i] == 1, ed, m_age[i] != 0);
        check_jc("rand_jc", i, STATS ? 16'(m_jobs[i]) : 16'd0);
        nreq = req_v[i];
        for (int b = 0; b < 4; b++) begin
          if (!nreq[b]) begin
            if ($urandom_range(3) == 0) nreq[b] = 1'b1;
          end else if (ed[b]) begin
            if ($urandom_range(2) != 0) nreq[b] = 1'b0;
          end else if (m_age[i] != 0 && m_owner[i] == b && $urandom_range(15) == 0) begin
            nreq[b] = 1'b0;
          end
        end
        req_v[i] = nreq;
        pvo_v[i] = 1'($urandom_range(1));
        if (m_age[i] == 0) begin
          if (nreq != 4'b0000) begin
            m_owner[i] = pick(nreq, m_ptr[i]);
            m_age[i]   = 1;
          end
        end else if (m_age[i] == lat_of[i] + 2) begin
          $display("[TB] rand inst%0d job done for requester %0d", i, m_owner[i]);
          m_ptr[i] = (m_owner[i] + 1) % 4;
          m_age[i] = 0;
          if (m_jobs[i] < 65535) m_jobs[i]++;
        end else begin
          m_age[i]++;
        end
      end
      tick();
    end

    // Three jobs after reset: counter reads 3 when enabled, 0 otherwise.
    rst_n[0] = 1'b0;
    req_v[0] = 4'b0000;
    tick();
    rst_n[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      req_v[0] = 4'b0001;
      tick();
      req_v[0] = 4'b0000;
      tick();
      tick();
      tick();
    end
    check_out("stats_idle", 0, 4'b0000, 2'd0, 1'b0, 4'b0000, 1'b0);
    check_jc("stats_three_jobs", 0, STATS ? 16'd3 : 16'd0);
    $display("[TB] stats: three jobs completed");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
